// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types for the four-motor sequencing controller
package motor_pkg;

   typedef logic [10:0] spd_t;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_ARMING,
      ST_RUN,
      ST_STOP
   } motor_state_t;

   // Per-frame action the sequencer asks of every motor slew unit
   typedef enum logic [1:0] {
      SLEW_HOLD,
      SLEW_ZERO,
      SLEW_TRACK,
      SLEW_DOWN
   } slew_op_t;

   function automatic spd_t clamp_spd(input spd_t cmd, input spd_t ceiling);
      return (cmd > ceiling) ? ceiling : cmd;
   endfunction

endpackage

// File: rtl/spd_slew.sv
// rtl/spd_slew.sv - one motor: clamped target register and rate-limited speed
module spd_slew
   import motor_pkg::*;
#(
   parameter int SLEW_STEP = 16,
   parameter int MAX_SPD   = 2000
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     cmd_vld,
   input  spd_t     cmd,
   input  slew_op_t op,
   output spd_t     spd
);

   localparam logic [11:0] STEP12 = 12'(SLEW_STEP);
   localparam logic [11:0] MAX12  = 12'(MAX_SPD);
   localparam spd_t        MAX11  = spd_t'(MAX_SPD);

   spd_t        tgt;
   logic [11:0] spd12;
   logic [11:0] tgt12;
   logic [11:0] gap12;
   logic [11:0] next12;

   // Next speed: move toward target or zero by at most one step, never past it
   always_comb begin
      spd12  = {1'b0, spd};
      tgt12  = {1'b0, tgt};
      gap12  = '0;
      next12 = spd12;
      case (op)
         SLEW_ZERO: next12 = '0;
         SLEW_TRACK: begin
            if (tgt12 > spd12) begin
               gap12  = tgt12 - spd12;
               next12 = (gap12 > STEP12) ? spd12 + STEP12 : tgt12;
            end else begin
               gap12  = spd12 - tgt12;
               next12 = (gap12 > STEP12) ? spd12 - STEP12 : tgt12;
            end
         end
         SLEW_DOWN: next12 = (spd12 > STEP12) ? spd12 - STEP12 : '0;
         default:   next12 = spd12;
      endcase
      if (next12 > MAX12) begin
         next12 = MAX12;
      end
   end

   // Target latches any qualified command; speed follows the sequencer's op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt <= '0;
         spd <= '0;
      end else begin
         if (cmd_vld) begin
            tgt <= clamp_spd(cmd, MAX11);
         end
         spd <= spd_t'(next12);
      end
   end

endmodule

// File: rtl/motor_seq_ctrl.sv
// rtl/motor_seq_ctrl.sv - ESC frame timing and arm/run/stop sequencing for four motors
module motor_seq_ctrl
   import motor_pkg::*;
#(
   parameter int FRAME_CYCLES = 1_000_000,
   parameter int ARM_FRAMES   = 50,
   parameter int SLEW_STEP    = 16,
   parameter int MAX_SPD      = 2000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic arm_req,
   input  logic disarm_req,
   input  logic kill,
   input  logic cmd_vld,
   input  spd_t frnt_cmd,
   input  spd_t bck_cmd,
   input  spd_t lft_cmd,
   input  spd_t rght_cmd,
   output spd_t frnt_spd,
   output spd_t bck_spd,
   output spd_t lft_spd,
   output spd_t rght_spd,
   output logic wrt,
   output logic motors_off,
   output logic armed
);

   localparam int              CW       = $clog2(FRAME_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(FRAME_CYCLES - 1);
   localparam logic [7:0]      ARM_LAST = 8'(ARM_FRAMES - 1);
   localparam logic [11:0]     STEP12   = 12'(SLEW_STEP);

   logic [CW-1:0] frame_cnt;
   logic          frame_tick;
   motor_state_t  state;
   logic [7:0]    arm_cnt;
   slew_op_t      slew_op;
   logic          stop_done;

   // The edge leaving count 0 is the frame edge; wrt is high for the cycle after it
   assign frame_tick = (frame_cnt == '0);

   // Every motor reaches zero on this frame edge when each is within one step
   assign stop_done = ({1'b0, frnt_spd} <= STEP12) && ({1'b0, bck_spd}  <= STEP12) &&
                      ({1'b0, lft_spd}  <= STEP12) && ({1'b0, rght_spd} <= STEP12);

   // Free-running frame counter and frame strobe, untouched by state or kill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         wrt       <= 1'b0;
      end else begin
         frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CW'(1);
         wrt       <= frame_tick;
      end
   end

   // Slew action for this edge; kill and disarm pre-empt the frame update
   always_comb begin
      slew_op = SLEW_HOLD;
      if (kill) begin
         slew_op = SLEW_ZERO;
      end else begin
         case (state)
            ST_OFF, ST_ARMING: slew_op = SLEW_ZERO;
            ST_RUN:  if (!disarm_req && frame_tick) slew_op = SLEW_TRACK;
            ST_STOP: if (frame_tick) slew_op = SLEW_DOWN;
            default: slew_op = SLEW_ZERO;
         endcase
      end
   end

   // Sequencer with registered motors_off/armed; priority kill > disarm > arm > frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_OFF;
         arm_cnt    <= '0;
         motors_off <= 1'b1;
         armed      <= 1'b0;
      end else if (kill) begin
         state      <= ST_OFF;
         arm_cnt    <= '0;
         motors_off <= 1'b1;
         armed      <= 1'b0;
      end else begin
         case (state)
            ST_OFF: begin
               if (arm_req) begin
                  state      <= ST_ARMING;
                  arm_cnt    <= '0;
                  motors_off <= 1'b0;
               end
            end
            ST_ARMING: begin
               if (disarm_req) begin
                  state      <= ST_OFF;
                  arm_cnt    <= '0;
                  motors_off <= 1'b1;
               end else if (frame_tick) begin
                  if (arm_cnt == ARM_LAST) begin
                     state   <= ST_RUN;
                     arm_cnt <= '0;
                     armed   <= 1'b1;
                  end else begin
                     arm_cnt <= arm_cnt + 8'd1;
                  end
               end
            end
            ST_RUN: begin
               if (disarm_req) begin
                  state <= ST_STOP;
                  armed <= 1'b0;
               end
            end
            ST_STOP: begin
               if (frame_tick && stop_done) begin
                  state      <= ST_OFF;
                  motors_off <= 1'b1;
               end
            end
            default: begin
               state      <= ST_OFF;
               motors_off <= 1'b1;
               armed      <= 1'b0;
            end
         endcase
      end
   end

   spd_slew #(.SLEW_STEP(SLEW_STEP), .MAX_SPD(MAX_SPD)) u_frnt (
      .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd(frnt_cmd), .op(slew_op), .spd(frnt_spd)
   );
   spd_slew #(.SLEW_STEP(SLEW_STEP), .MAX_SPD(MAX_SPD)) u_bck (
      .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd(bck_cmd), .op(slew_op), .spd(bck_spd)
   );
   spd_slew #(.SLEW_STEP(SLEW_STEP), .MAX_SPD(MAX_SPD)) u_lft (
      .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd(lft_cmd), .op(slew_op), .spd(lft_spd)
   );
   spd_slew #(.SLEW_STEP(SLEW_STEP), .MAX_SPD(MAX_SPD)) u_rght (
      .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd(rght_cmd), .op(slew_op), .spd(rght_spd)
   );

endmodule

// File: doc/motor_seq_ctrl.md
MOTOR_SEQ_CTRL -- requirements
Module: motor_seq_ctrl

Interface
REQ-001 Parameter FRAME_CYCLES, default 1_000_000, clk cycles per ESC update frame (20 ms at 50 MHz), legal range 4..2^20.
REQ-002 Parameter ARM_FRAMES, default 50, number of zero-speed frames sent before speed commands are honoured, legal range 1..255.
REQ-003 Parameter SLEW_STEP, default 16, maximum per-frame change of any motor speed, in LSBs, legal range 1..2047.
REQ-004 Parameter MAX_SPD, default 2000, clamp ceiling applied to all speed commands.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 arm_req  in  1  single-cycle request to leave OFF.
REQ-008 disarm_req  in  1  single-cycle request for a controlled ramp-down.
REQ-009 kill  in  1  level emergency stop; overrides everything.
REQ-010 cmd_vld  in  1  qualifies the four command inputs.
REQ-011 frnt_cmd, bck_cmd, lft_cmd, rght_cmd  in  11 each  requested motor speeds.
REQ-012 frnt_spd, bck_spd, lft_spd, rght_spd  out  11 each  registered speeds to the ESC bank.
REQ-013 wrt  out  1  registered single-cycle frame strobe to the ESC bank.
REQ-014 motors_off  out  1  registered; 1 forces the ESC bank to zero.
REQ-015 armed  out  1  registered; 1 in RUN only.

Function
REQ-016 Free-running frame counter counts 0..FRAME_CYCLES-1 and wraps, independent of state and kill.
REQ-017 wrt shall be 1 exactly in the cycle the counter equals 0; period FRAME_CYCLES, first pulse on the first cycle after reset release.
REQ-018 Speed outputs and frame-driven state transitions update only on the edge where the counter wraps to 0, so speeds are stable throughout every wrt cycle.
REQ-019 On cmd_vld=1, each cmd shall be clamped to MAX_SPD and latched into a per-motor target register; the latest latched value is used at the next frame edge.
REQ-020 States: OFF, ARMING, RUN, STOP.
REQ-021 OFF: motors_off=1, speeds 0, armed=0; arm_req with kill=0 moves to ARMING on the next clk edge.
REQ-022 ARMING: motors_off=0, speeds held at 0; count frame edges; after ARM_FRAMES frame edges, move to RUN.
REQ-023 ARMING: disarm_req moves to OFF on the next clk edge.
REQ-024 RUN: at each frame edge, each speed moves toward its target by min(|target-speed|, SLEW_STEP), up or down; no overshoot.
REQ-025 RUN: disarm_req moves to STOP.
REQ-026 STOP: targets are ignored; speeds ramp toward 0 by SLEW_STEP per frame edge.
REQ-027 STOP: at the frame edge where all four speeds are 0, move to OFF.
REQ-028 kill=1 in any state: on the next clk edge, move to OFF, zero all speeds, set motors_off=1, and clear the arming counter; kill does not wait for a frame edge.
REQ-029 arm_req outside OFF is ignored; arm_req in OFF while kill=1 is ignored.
REQ-030 Priority when events coincide: kill > disarm_req > arm_req > frame-edge update.
REQ-031 Slew arithmetic shall use 12-bit intermediates; results never wrap below 0 or above MAX_SPD.

Reset
REQ-032 While rst_n=0: state OFF, all speeds 0, all targets 0, counters 0, wrt=0, motors_off=1, armed=0.
REQ-033 Reset asserted mid-ramp shall take effect asynchronously, with no residual target or speed after release.

Structure
REQ-034 Shared package motor_pkg holds the state enum type and the 11-bit speed typedef.
REQ-035 Sub-module spd_slew holds one motor's target register, clamp and slew step; instantiate it four times.
REQ-036 The frame counter and FSM reside in motor_seq_ctrl.
REQ-037 Outputs connect directly, port for port, to the four-motor ESC bank.

Verification (FRAME_CYCLES=10, ARM_FRAMES=3, SLEW_STEP=100, MAX_SPD=2000)
REQ-038 Scenario: reset, run 35 cycles -> wrt pulses at cycles 1, 11, 21, 31; motors_off=1; all speeds 0.
REQ-039 Scenario: arm_req, then all cmds set to 250 -> 3 zero-speed frames, then speeds 100, 200, 250, 250; armed=1 from RUN entry.
REQ-040 Scenario: frnt_cmd=2047 in RUN -> target clamps to 2000; speed increases by 100 per frame and holds at 2000.
REQ-041 Scenario: from speeds 250, disarm_req -> speeds 150, 50, 0; OFF entered at the frame edge reaching 0, with motors_off=1 and armed=0.
REQ-042 Scenario: kill mid-frame in RUN at speed 800 -> next clk edge speeds 0 and motors_off=1; the following arm_req restarts a full 3-frame ARMING.
REQ-043 Scenario: disarm_req and kill in the same cycle, and arm_req with kill=1 -> OFF and no ARMING entry.
